axi_lmem_responder: RTL

- Single-beat AXI4 slave memory model (local memory, "lmem") for the testbench.
- It is the responder that sits on the LSU/DMA bridge's lmem-side AXI port (s0_axi_*).
- Serves one outstanding write and one outstanding read at a time from a 64-bit-wide byte-strobed array.
- Read latency is programmable; optional address-window checking returns error responses.

---
 rtl/lmem_pkg.sv | 14 +
 rtl/axi_lmem_array.sv | 38 +++
 rtl/axi_lmem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lmem_pkg.sv
// rtl/lmem_pkg.sv - shared FSM states, response codes and index-width helper for the lmem responder
package lmem_pkg;

  typedef enum logic [0:0] {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/axi_lmem_array.sv
// rtl/axi_lmem_array.sv - 64-bit word store with one byte-masked write port and one registered read port
module axi_lmem_array
  import lmem_pkg::*;
#(
  parameter int DEPTH = 8192,
  localparam int IW = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read-before-write: a same-cycle write is not visible in the sampled word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lmem_responder.sv
// rtl/axi_lmem_responder.sv - single-beat AXI4 lmem responder; LMEM_RANGE_CHECK_EN enables address-window SLVERR
module axi_lmem_responder
  import lmem_pkg::*;
#(
  parameter int          TAG       = 1,
  parameter int          DEPTH     = 8192,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           axi_awvalid,
  output logic           axi_awready,
  input  logic [TAG-1:0] axi_awid,
  input  logic [31:0]    axi_awaddr,
  input  logic [2:0]     axi_awsize,
  input  logic           axi_wvalid,
  output logic           axi_wready,
  input  logic [63:0]    axi_wdata,
  input  logic [7:0]     axi_wstrb,
  output logic           axi_bvalid,
  input  logic           axi_bready,
  output logic [1:0]     axi_bresp,
  output logic [TAG-1:0] axi_bid,
  input  logic           axi_arvalid,
  output logic           axi_arready,
  input  logic [TAG-1:0] axi_arid,
  input  logic [31:0]    axi_araddr,
  input  logic [2:0]     axi_arsize,
  output logic           axi_rvalid,
  input  logic           axi_rready,
  output logic [TAG-1:0] axi_rid,
  output logic [63:0]    axi_rdata,
  output logic [1:0]     axi_rresp,
  output logic           axi_rlast
);

  localparam int IW = idx_width(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  function automatic logic [IW-1:0] word_idx(input logic [31:0] addr);
    return IW'((addr - BASE_ADDR) >> 3);
  endfunction

  logic aw_oow, ar_oow;
`ifdef LMEM_RANGE_CHECK_EN
  assign aw_oow = (axi_awaddr < BASE_ADDR) ||
                  ({1'b0, axi_awaddr} >= ({1'b0, BASE_ADDR} + 33'(8 * DEPTH)));
  assign ar_oow = (axi_araddr < BASE_ADDR) ||
                  ({1'b0, axi_araddr} >= ({1'b0, BASE_ADDR} + 33'(8 * DEPTH)));
`else
  assign aw_oow = 1'b0;
  assign ar_oow = 1'b0;
`endif

  logic unused_size;
  assign unused_size = ^{axi_awsize, axi_arsize};

  wr_state_e      wr_state;
  logic           aw_held, w_held, aw_oow_q;
  logic [TAG-1:0] awid_q;
  logic [IW-1:0]  awidx_q;
  logic [63:0]    wdata_q;
  logic [7:0]     wstrb_q;
  logic           aw_hs, w_hs, wr_commit, cur_oow;
  logic [TAG-1:0] cur_awid;
  logic [IW-1:0]  cur_widx;
  logic [63:0]    cur_wdata;
  logic [7:0]     cur_wstrb;

  assign aw_hs     = axi_awvalid & axi_awready;
  assign w_hs      = axi_wvalid & axi_wready;
  assign wr_commit = (wr_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
  assign cur_awid  = aw_held ? awid_q   : axi_awid;
  assign cur_widx  = aw_held ? awidx_q  : word_idx(axi_awaddr);
  assign cur_oow   = aw_held ? aw_oow_q : aw_oow;
  assign cur_wdata = w_held  ? wdata_q  : axi_wdata;
  assign cur_wstrb = w_held  ? wstrb_q  : axi_wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state    <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      axi_awready <= 1'b1;
      axi_wready  <= 1'b1;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      axi_bid     <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held     <= 1'b1;
            axi_awready <= 1'b0;
            awid_q      <= axi_awid;
            awidx_q     <= word_idx(axi_awaddr);
            aw_oow_q    <= aw_oow;
          end
          if (w_hs) begin
            w_held     <= 1'b1;
            axi_wready <= 1'b0;
            wdata_q    <= axi_wdata;
            wstrb_q    <= axi_wstrb;
          end
          // The commit cycle releases both holding slots; readies stay low until B completes.
          if (wr_commit) begin
            wr_state    <= W_RESP;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b1;
            axi_bid     <= cur_awid;
            axi_bresp   <= cur_oow ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            wr_state    <= W_IDLE;
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  rd_state_e      rd_state;
  logic [3:0]     rd_cnt;
  logic [TAG-1:0] arid_q;
  logic [IW-1:0]  aridx_q;
  logic           ar_oow_q, ar_hs, mem_re;
  logic [IW-1:0]  mem_raddr;
  logic [63:0]    mem_rdata;

  assign ar_hs     = axi_arvalid & axi_arready;
  assign mem_re    = ((rd_state == R_IDLE) && ar_hs && (RD_LAT == 1)) ||
                     ((rd_state == R_WAIT) && (rd_cnt == 4'd1));
  assign mem_raddr = (rd_state == R_IDLE) ? word_idx(axi_araddr) : aridx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state    <= R_IDLE;
      rd_cnt      <= '0;
      axi_arready <= 1'b1;
      axi_rvalid  <= 1'b0;
      axi_rresp   <= RESP_OKAY;
      axi_rid     <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            axi_arready <= 1'b0;
            arid_q      <= axi_arid;
            aridx_q     <= word_idx(axi_araddr);
            ar_oow_q    <= ar_oow;
            rd_cnt      <= LAT_M1;
            if (RD_LAT == 1) begin
              rd_state   <= R_DATA;
              axi_rvalid <= 1'b1;
              axi_rid    <= axi_arid;
              axi_rresp  <= ar_oow ? RESP_SLVERR : RESP_OKAY;
            end else begin
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          // Leaving on count 1 lands the first rvalid exactly RD_LAT cycles after AR.
          if (rd_cnt == 4'd1) begin
            rd_state   <= R_DATA;
            rd_cnt     <= '0;
            axi_rvalid <= 1'b1;
            axi_rid    <= arid_q;
            axi_rresp  <= ar_oow_q ? RESP_SLVERR : RESP_OKAY;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            rd_state    <= R_IDLE;
            axi_rvalid  <= 1'b0;
            axi_arready <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign axi_rlast = axi_rvalid;
  assign axi_rdata = (axi_rresp == RESP_SLVERR) ? 64'd0 : mem_rdata;

  axi_lmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (wr_commit & ~cur_oow),
    .waddr (cur_widx),
    .wdata (cur_wdata),
    .wstrb (cur_wstrb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule
